// File: rtl/prod_accum.sv
// Multiply-accumulate back end: sums a programmed number of 8-bit products
// arriving over valid/ready and presents the result on a held output handshake.
module prod_accum #(
  parameter int ACC_W = 16,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       prod,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] sum,
  output logic             overflow,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [LEN_W-1:0] count;
  logic [LEN_W-1:0] len_q;
  logic             ovf;

  logic [ACC_W:0]   add;
  logic [LEN_W-1:0] count_next;
  logic             xfer;

  always_comb begin
    add        = {1'b0, acc} + {{(ACC_W + 1 - 8){1'b0}}, prod};
    count_next = count + LEN_W'(1);
    xfer       = in_valid && (state == ACC);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      count <= '0;
      len_q <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            len_q <= len;
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
            state <= (len == '0) ? DONE : ACC;
          end
        end
        ACC: begin
          if (xfer) begin
            acc   <= add[ACC_W-1:0];
            // Carry out of the top bit is sticky for the rest of the job.
            ovf   <= ovf | add[ACC_W];
            count <= count_next;
            if (count_next == len_q) state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == ACC);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign sum       = acc;
  assign overflow  = ovf;

endmodule

// File: tb/tb_prod_accum.sv
// Scoreboard bench for prod_accum: a 16-bit default instance and an 8-bit
// accumulator instance for wrap/overflow behaviour.
module tb_prod_accum;

  typedef struct packed {
    logic [15:0] sum;
    logic        ovf;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] start_s     = '0;
  logic [1:0] in_valid_s  = '0;
  logic [1:0] out_ready_s = '0;
  logic [1:0] in_ready_s;
  logic [1:0] out_valid_s;
  logic [1:0] ovf_s;
  logic [1:0] busy_s;
  logic [3:0] len_s  [2];
  logic [7:0] prod_s [2];
  logic [15:0] sum16;
  logic [7:0]  sum8;

  int errors = 0;
  int checks = 0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  prod_accum #(.ACC_W(16), .LEN_W(4)) dut16 (
    .clk(clk), .rst(rst), .start(start_s[0]), .len(len_s[0]),
    .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]), .prod(prod_s[0]),
    .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]), .sum(sum16),
    .overflow(ovf_s[0]), .busy(busy_s[0])
  );

  prod_accum #(.ACC_W(8), .LEN_W(4)) dut8 (
    .clk(clk), .rst(rst), .start(start_s[1]), .len(len_s[1]),
    .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]), .prod(prod_s[1]),
    .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]), .sum(sum8),
    .overflow(ovf_s[1]), .busy(busy_s[1])
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops an expectation each time a result is handed over.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid_s[0] && out_ready_s[0]) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut16_unexpected_result: got sum %0d expected none", sum16);
      end else begin
        e = q0.pop_front();
        check("dut16_sum", sum16, e.sum);
        check("dut16_overflow", {15'b0, ovf_s[0]}, {15'b0, e.ovf});
      end
    end
    if (out_valid_s[1] && out_ready_s[1]) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut8_unexpected_result: got sum %0d expected none", sum8);
      end else begin
        e = q1.pop_front();
        check("dut8_sum", {8'b0, sum8}, e.sum);
        check("dut8_overflow", {15'b0, ovf_s[1]}, {15'b0, e.ovf});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_job(input int d, input logic [3:0] n);
    start_s[d] = 1'b1;
    len_s[d]   = n;
    step();
    start_s[d] = 1'b0;
  endtask

  task automatic feed(input int d, input logic [7:0] p);
    check("in_ready_in_acc", {15'b0, in_ready_s[d]}, 16'd1);
    in_valid_s[d] = 1'b1;
    prod_s[d]     = p;
    step();
    in_valid_s[d] = 1'b0;
  endtask

  initial begin
    len_s[0] = '0; len_s[1] = '0; prod_s[0] = '0; prod_s[1] = '0;
    step(); step();
    rst = 1'b0;
    check("reset_in_ready", {14'b0, in_ready_s}, 16'd0);
    check("reset_out_valid", {14'b0, out_valid_s}, 16'd0);
    check("reset_busy", {14'b0, busy_s}, 16'd0);
    check("reset_sum16", sum16, 16'd0);
    check("reset_overflow", {14'b0, ovf_s}, 16'd0);

    // len=3, 225 back to back
    out_ready_s[0] = 1'b1;
    q0.push_back('{sum: 16'd675, ovf: 1'b0});
    begin_job(0, 4'd3);
    feed(0, 8'd225); feed(0, 8'd225); feed(0, 8'd225);
    check("len3_latency_out_valid", {15'b0, out_valid_s[0]}, 16'd1);
    step();
    check("len3_back_to_idle", {15'b0, busy_s[0]}, 16'd0);

    // len=4 with a 2-cycle gap
    q0.push_back('{sum: 16'd100, ovf: 1'b0});
    begin_job(0, 4'd4);
    feed(0, 8'd10); feed(0, 8'd20);
    for (int i = 0; i < 2; i++) begin
      check("gap_in_ready", {15'b0, in_ready_s[0]}, 16'd1);
      check("gap_no_done", {15'b0, out_valid_s[0]}, 16'd0);
      step();
    end
    feed(0, 8'd30);
    check("gap_not_done_early", {15'b0, out_valid_s[0]}, 16'd0);
    feed(0, 8'd40);
    check("gap_done", {15'b0, out_valid_s[0]}, 16'd1);
    step();

    // len=0
    q0.push_back('{sum: 16'd0, ovf: 1'b0});
    in_valid_s[0] = 1'b1; prod_s[0] = 8'd77;
    begin_job(0, 4'd0);
    check("len0_out_valid", {15'b0, out_valid_s[0]}, 16'd1);
    check("len0_in_ready", {15'b0, in_ready_s[0]}, 16'd0);
    step();
    in_valid_s[0] = 1'b0;
    check("len0_idle", {15'b0, busy_s[0]}, 16'd0);

    // backpressure with sum=50
    out_ready_s[0] = 1'b0;
    q0.push_back('{sum: 16'd50, ovf: 1'b0});
    begin_job(0, 4'd2);
    feed(0, 8'd20); feed(0, 8'd30);
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", {15'b0, out_valid_s[0]}, 16'd1);
      check("bp_sum", sum16, 16'd50);
      check("bp_in_ready", {15'b0, in_ready_s[0]}, 16'd0);
      start_s[0] = i[0]; in_valid_s[0] = ~i[0]; prod_s[0] = 8'd99; len_s[0] = 4'd3;
      step();
    end
    start_s[0] = 1'b1; in_valid_s[0] = 1'b0; out_ready_s[0] = 1'b1;
    step();
    start_s[0] = 1'b0;
    check("bp_release_idle", {15'b0, busy_s[0]}, 16'd0);
    check("bp_release_out_valid", {15'b0, out_valid_s[0]}, 16'd0);
    check("bp_sum_kept", sum16, 16'd50);

    // reset mid-job
    begin_job(0, 4'd5);
    feed(0, 8'd1); feed(0, 8'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_busy", {15'b0, busy_s[0]}, 16'd0);
    check("midrst_sum", sum16, 16'd0);
    check("midrst_in_ready", {15'b0, in_ready_s[0]}, 16'd0);
    q0.push_back('{sum: 16'd7, ovf: 1'b0});
    begin_job(0, 4'd1);
    feed(0, 8'd7);
    check("midrst_done", {15'b0, out_valid_s[0]}, 16'd1);
    step();

    // 8-bit accumulator: wrap and overflow, then clean job
    out_ready_s[1] = 1'b1;
    q1.push_back('{sum: 16'd44, ovf: 1'b1});
    begin_job(1, 4'd2);
    feed(1, 8'd200); feed(1, 8'd100);
    check("acc8_done", {15'b0, out_valid_s[1]}, 16'd1);
    step();
    q1.push_back('{sum: 16'd5, ovf: 1'b0});
    begin_job(1, 4'd1);
    feed(1, 8'd5);
    step();

    step();
    check("dut16_all_results_seen", 16'(q0.size()), 16'd0);
    check("dut8_all_results_seen", 16'(q1.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
